// File: rtl/mips_mux_ctrl.sv
// mips_mux_ctrl
// -------------
// Multicycle control FSM for the MIPS datapath. Each instruction is walked
// through fetch / decode / execute / memory / writeback, and every state
// drives the datapath mux selects and the write enables.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   opcode      IR[31:26], valid from DECODE onward
//   zero        ALU zero flag (same cycle)
//   mem_ready   memory completes the access this cycle
//   iord_sel    0=PC, 1=ALUOut
//   alu_src_a   0=PC, 1=regA
//   alu_src_b   0=regB, 1=4, 2=sext imm, 3=sext imm<<2
//   alu_op      0=add, 1=sub, 2=funct-decoded
//   reg_dst     0=rt, 1=rd, 2=r31
//   mem_to_reg  0=ALUOut, 1=MDR, 2=PC, 3=imm<<16
//   pc_source   0=ALU, 1=ALUOut, 2=jump target, 3=exception vector
//   pc_write, ir_write, reg_write, mem_write   write enables
//   illegal     one-cycle pulse while in EXC
//
// Parameter
//   EXC_ON_ILLEGAL  1: unknown opcode enters EXC; 0: treated as a NOP
//
// Build option
//   MIPS_CTRL_JAL_EN  defined: opcode 0x03 executes JAL. Undefined: the JAL
//                     state is absent and 0x03 is an unknown opcode.
//
// state    | meaning
// ---------+------------------------------------------------
// RESET    | post-reset idle, all outputs low
// FETCH    | read instruction, PC+4; waits for mem_ready
// DECODE   | dispatch on opcode, branch target into ALUOut
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read; waits for mem_ready
// MEM_WB   | MDR -> rt
// MEM_WR   | data write; waits for mem_ready
// R_EXEC   | R-type ALU operation
// R_WB     | ALUOut -> rd
// I_EXEC   | addi ALU operation
// I_WB     | ALUOut -> rt
// LUI_WB   | imm<<16 -> rt
// BRANCH   | beq/bne compare, conditional PC load
// JUMP     | PC <- jump target
// JAL      | r31 <- PC, PC <- jump target
// EXC      | PC <- exception vector, illegal pulse

module mips_mux_ctrl #(
  parameter logic EXC_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_I_EXEC   = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_LUI_WB   = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_JUMP     = 4'd13;
`ifdef MIPS_CTRL_JAL_EN
  localparam logic [3:0] S_JAL      = 4'd14;
`endif
  localparam logic [3:0] S_EXC      = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef MIPS_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state;
  logic [3:0] state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    iord_sel   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 3'd0;
    pc_source  = 2'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_RESET: state_nxt = S_FETCH;

      S_FETCH: begin
        alu_src_b = 2'd1;
        // IR and PC load together on the cycle memory delivers the word
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:       state_nxt = S_R_EXEC;
          OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
          OP_ADDI:        state_nxt = S_I_EXEC;
          OP_LUI:         state_nxt = S_LUI_WB;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:         state_nxt = S_JAL;
`endif
          default:        state_nxt = EXC_ON_ILLEGAL ? S_EXC : S_FETCH;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iord_sel = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end

      S_MEM_WB: begin
        mem_to_reg = 3'd1;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        // write strobe stays up for the whole wait so memory sees a stable request
        iord_sel  = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_nxt = S_R_WB;
      end

      S_R_WB: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

      S_LUI_WB: begin
        mem_to_reg = 3'd3;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        // bne (0x05) is the only other opcode that reaches here
        pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
        state_nxt = S_FETCH;
      end

      S_JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end

`ifdef MIPS_CTRL_JAL_EN
      S_JAL: begin
        // PC was already advanced in FETCH, so the link value is PC itself
        reg_dst    = 2'd2;
        mem_to_reg = 3'd2;
        reg_write  = 1'b1;
        pc_source  = 2'd2;
        pc_write   = 1'b1;
        state_nxt  = S_FETCH;
      end
`endif

      S_EXC: begin
        pc_source = 2'd3;
        pc_write  = 1'b1;
        illegal   = 1'b1;
        state_nxt = S_FETCH;
      end

      default: state_nxt = S_RESET;
    endcase
  end

endmodule
